// File: rtl/dram_write_arbiter_if.sv
// dram_write_arbiter_if: request, DRAM issue and status signals of the two-requester write arbiter
interface dram_write_arbiter_if #(
  parameter int ADDR_WIDTH = 39,
  parameter int DATA_WIDTH = 512
);
  logic                  req0_en;
  logic                  req1_en;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [7:0]            req0_len;
  logic [7:0]            req1_len;
  logic [DATA_WIDTH-1:0] req0_data;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req0_ack;
  logic                  req1_ack;
  logic [ADDR_WIDTH-1:0] dram_write_addr;
  logic [7:0]            dram_write_len;
  logic [DATA_WIDTH-1:0] dram_write_data;
  logic                  dram_write_en;
  logic                  dram_write_busy;
  logic                  grant_id;
  logic                  timeout_err;
  logic [15:0]           grant_cnt0;
  logic [15:0]           grant_cnt1;
  modport slave (
    input  req0_en, req1_en, req0_addr, req1_addr, req0_len, req1_len, req0_data, req1_data,
    input  dram_write_busy,
    output req0_ack, req1_ack, dram_write_addr, dram_write_len, dram_write_data, dram_write_en,
    output grant_id, timeout_err, grant_cnt0, grant_cnt1
  );
  modport master (
    output req0_en, req1_en, req0_addr, req1_addr, req0_len, req1_len, req0_data, req1_data,
    output dram_write_busy,
    input  req0_ack, req1_ack, dram_write_addr, dram_write_len, dram_write_data, dram_write_en,
    input  grant_id, timeout_err, grant_cnt0, grant_cnt1
  );
endinterface

// File: rtl/dram_write_arbiter.sv
// dram_write_arbiter: round-robin arbiter issuing one DRAM write burst at a time, with busy timeout
module dram_write_arbiter #(
  parameter int ADDR_WIDTH   = 39,
  parameter int DATA_WIDTH   = 512,
  parameter int BUSY_TIMEOUT = 255
) (
  input logic           m_axi_aclk,
  input logic           reset,
  dram_write_arbiter_if.slave bus
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t                state;
  state_t                state_nxt;
  logic                  ptr;
  logic                  gid;
  logic                  terr;
  logic                  win;
  logic                  grant;
  logic                  timeout;
  logic                  done;
  logic                  en;
  logic                  busy;
  logic [TW-1:0]         tcnt;
  logic [15:0]           cnt0;
  logic [15:0]           cnt1;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            len;
  logic [DATA_WIDTH-1:0] data;
  assign busy = bus.dram_write_busy;
  assign win  = (bus.req0_en & bus.req1_en) ? ptr : bus.req1_en;
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    timeout   = 1'b0;
    done      = 1'b0;
    en        = 1'b0;
    unique case (state)
      IDLE: begin
        grant     = (bus.req0_en | bus.req1_en) & ~busy;
        state_nxt = grant ? ISSUE : IDLE;
      end
      ISSUE: begin
        en        = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // tcnt holds the number of WAIT_BUSY cycles already spent without busy
        timeout   = ~busy & (tcnt == TW'(BUSY_TIMEOUT - 1));
        state_nxt = busy ? WAIT_DONE : timeout ? IDLE : WAIT_BUSY;
      end
      WAIT_DONE: begin
        done      = ~busy;
        state_nxt = done ? IDLE : WAIT_DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge m_axi_aclk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      tcnt  <= '0;
      ptr   <= 1'b0;
      gid   <= 1'b0;
      terr  <= 1'b0;
      cnt0  <= '0;
      cnt1  <= '0;
      addr  <= '0;
      len   <= '0;
      data  <= '0;
    end else begin
      state <= state_nxt;
      tcnt  <= (state == WAIT_BUSY) ? tcnt + 1'b1 : '0;
      if (grant) begin
        gid  <= win;
        addr <= win ? bus.req1_addr : bus.req0_addr;
        len  <= win ? bus.req1_len : bus.req0_len;
        data <= win ? bus.req1_data : bus.req0_data;
      end
      if (timeout) terr <= 1'b1;
      if (timeout | done) ptr <= ~gid;
      if (done & ~gid) cnt0 <= cnt0 + 16'd1;
      if (done & gid) cnt1 <= cnt1 + 16'd1;
    end
  end
  assign bus.dram_write_en   = en;
  assign bus.req0_ack        = en & ~gid;
  assign bus.req1_ack        = en & gid;
  assign bus.dram_write_addr = addr;
  assign bus.dram_write_len  = len;
  assign bus.dram_write_data = data;
  assign bus.grant_id        = gid;
  assign bus.timeout_err     = terr;
  assign bus.grant_cnt0      = cnt0;
  assign bus.grant_cnt1      = cnt1;
endmodule

// File: tb/tb_dram_write_arbiter.sv
// tb_dram_write_arbiter: directed checks of grant latency, round-robin, busy blocking, timeout and reset
module tb_dram_write_arbiter;
  localparam int AW = 39;
  localparam int DW = 512;
  localparam logic [AW-1:0] A0 = 39'h80000000;
  localparam logic [AW-1:0] B0 = 39'h0000001000;
  localparam logic [AW-1:0] B1 = 39'h0000002000;
  localparam logic [DW-1:0] D0 = {16{32'hA5A50000}};
  localparam logic [DW-1:0] D1 = {16{32'h5A5A1111}};
  logic       clk = 1'b0;
  logic       rst;
  logic       model_on;
  logic       busy_f;
  logic [1:0] mc = '0;
  int         checks = 0;
  int         errors = 0;
  always #5 clk = ~clk;
  dram_write_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  dram_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUSY_TIMEOUT(255)) dut (
    .m_axi_aclk(clk),
    .reset     (rst),
    .bus       (bus)
  );
  // controller model: busy rises the cycle after the issue strobe and stays for 3 cycles
  always @(posedge clk) begin
    if (bus.dram_write_en) mc <= 2'd3;
    else if (mc != 2'd0) mc <= mc - 2'd1;
  end
  assign bus.dram_write_busy = model_on ? (mc != 2'd0) : busy_f;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_en(input string tag);
    for (int n = 0; n < 40 && bus.dram_write_en !== 1'b1; n++) @(negedge clk);
    chk(tag, 64'(bus.dram_write_en), 64'd1);
  endtask
  task automatic wait_cnt(input string tag, input logic [15:0] c0, input logic [15:0] c1);
    for (int n = 0; n < 40 && !(bus.grant_cnt0 === c0 && bus.grant_cnt1 === c1); n++) @(negedge clk);
    chk(tag, {bus.grant_cnt0, bus.grant_cnt1}, {c0, c1});
  endtask
  initial begin
    rst = 1'b1;
    model_on = 1'b1;
    busy_f = 1'b0;
    bus.req0_en = 1'b0;
    bus.req1_en = 1'b0;
    bus.req0_addr = '0;
    bus.req1_addr = '0;
    bus.req0_len = '0;
    bus.req1_len = '0;
    bus.req0_data = '0;
    bus.req1_data = '0;
    #12;
    chk("rst_en", 64'(bus.dram_write_en), 0);
    chk("rst_acks", {bus.req0_ack, bus.req1_ack}, 0);
    chk("rst_cnts", {bus.grant_cnt0, bus.grant_cnt1}, 0);
    chk("rst_to_gid", {bus.timeout_err, bus.grant_id}, 0);
    chk("rst_addr", 64'(bus.dram_write_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.req0_en = 1'b1;
    bus.req0_addr = A0;
    bus.req0_len = 8'd0;
    bus.req0_data = D0;
    @(negedge clk);
    chk("single_en", 64'(bus.dram_write_en), 1);
    chk("single_acks", {bus.req0_ack, bus.req1_ack}, 64'b10);
    chk("single_addr", 64'(bus.dram_write_addr), 64'(A0));
    chk("single_gid", 64'(bus.grant_id), 0);
    bus.req0_en = 1'b0;
    @(negedge clk);
    chk("single_pulse", {bus.dram_write_en, bus.req0_ack}, 0);
    @(negedge clk);
    bus.req0_data = D1;
    bus.req0_addr = 39'h123;
    wait_cnt("single_cnt", 16'd1, 16'd0);
    chk("hold_data", 64'(bus.dram_write_data === D0), 1);
    chk("hold_addr", 64'(bus.dram_write_addr), 64'(A0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req0_addr = B0;
    bus.req0_data = D0;
    bus.req1_addr = B1;
    bus.req1_len = 8'd5;
    bus.req1_data = D1;
    bus.req0_en = 1'b1;
    bus.req1_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_en($sformatf("rr_en%0d", i));
      chk($sformatf("rr_gid%0d", i), 64'(bus.grant_id), 64'(i % 2));
      chk($sformatf("rr_acks%0d", i), {bus.req0_ack, bus.req1_ack}, (i % 2 == 0) ? 64'b10 : 64'b01);
      chk($sformatf("rr_addr%0d", i), 64'(bus.dram_write_addr), (i % 2 == 0) ? 64'(B0) : 64'(B1));
      @(negedge clk);
    end
    bus.req0_en = 1'b0;
    bus.req1_en = 1'b0;
    wait_cnt("rr_cnts", 16'd2, 16'd2);
    model_on = 1'b0;
    busy_f = 1'b1;
    bus.req1_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("blk%0d", i), {bus.dram_write_en, bus.req0_ack, bus.req1_ack}, 0);
    end
    busy_f = 1'b0;
    @(negedge clk);
    chk("blk_grant", {bus.dram_write_en, bus.req0_ack, bus.req1_ack}, 64'b101);
    chk("blk_gid", 64'(bus.grant_id), 1);
    chk("blk_len", 64'(bus.dram_write_len), 5);
    bus.req1_en = 1'b0;
    repeat (255) @(negedge clk);
    chk("to_early", 64'(bus.timeout_err), 0);
    @(negedge clk);
    chk("to_set", 64'(bus.timeout_err), 1);
    chk("to_cnts", {bus.grant_cnt0, bus.grant_cnt1}, {16'd2, 16'd2});
    model_on = 1'b1;
    bus.req0_en = 1'b1;
    bus.req1_en = 1'b1;
    @(negedge clk);
    chk("to_next_en", 64'(bus.dram_write_en), 1);
    chk("to_next_acks", {bus.req0_ack, bus.req1_ack}, 64'b10);
    chk("to_sticky", 64'(bus.timeout_err), 1);
    bus.req0_en = 1'b0;
    bus.req1_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_en_acks", {bus.dram_write_en, bus.req0_ack, bus.req1_ack}, 0);
    chk("mid_to_gid", {bus.timeout_err, bus.grant_id}, 0);
    chk("mid_cnts", {bus.grant_cnt0, bus.grant_cnt1}, 0);
    chk("mid_addr_len", {25'd0, bus.dram_write_addr}, 0);
    chk("mid_len", 64'(bus.dram_write_len), 0);
    chk("mid_data", 64'(bus.dram_write_data === '0), 1);
    bus.req1_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_grant", {bus.dram_write_en, bus.req0_ack, bus.req1_ack}, 64'b101);
    chk("post_addr", 64'(bus.dram_write_addr), 64'(B1));
    bus.req1_en = 1'b0;
    wait_cnt("post_cnts", 16'd0, 16'd1);
    chk("post_data", 64'(bus.dram_write_data === D1), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dram_write_arbiter.md
DRAM_WRITE_ARBITER -- requirements
Module: dram_write_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 39: width of all DRAM byte addresses.
REQ-002 Parameter DATA_WIDTH, default 512: width of one DRAM write beat.
REQ-003 Parameter BUSY_TIMEOUT, default 255: maximum number of cycles to wait for dram_write_busy to rise after an issue.
REQ-004 m_axi_aclk  in  1  single clock; all logic is on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 reqN_en  in  1  (N=0,1) level request; the requester holds it and its reqN_* fields stable until reqN_ack.
REQ-007 reqN_addr  in  ADDR_WIDTH  (N=0,1) write address.
REQ-008 reqN_len  in  8  (N=0,1) AXI burst length (beats-1).
REQ-009 reqN_data  in  DATA_WIDTH  (N=0,1) write data.
REQ-010 reqN_ack  out  1  (N=0,1) one-cycle pulse; the request was accepted.
REQ-011 dram_write_addr  out  ADDR_WIDTH  registered address to the DRAM controller.
REQ-012 dram_write_len  out  8  registered burst length to the DRAM controller.
REQ-013 dram_write_data  out  DATA_WIDTH  registered data to the DRAM controller.
REQ-014 dram_write_en  out  1  one-cycle issue strobe to the DRAM controller.
REQ-015 dram_write_busy  in  1  DRAM controller write-in-progress flag.
REQ-016 grant_id  out  1  requester owning the current or most recent transaction.
REQ-017 timeout_err  out  1  sticky flag: busy never rose after an issue.
REQ-018 grant_cnt0 and grant_cnt1  out  16 each  completed-transaction counter per requester.

Function
REQ-019 The FSM shall have exactly four states: IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-020 IDLE: when any reqN_en=1 and dram_write_busy=0, the block shall:
- select the winner;
- latch the winner's addr, len and data into the dram_write_* registers;
- set grant_id;
- go to ISSUE.
REQ-021 IDLE with dram_write_busy=1 shall not grant, even if requests are pending.
REQ-022 Arbitration shall be round-robin with a 1-bit priority pointer (0 after reset):
- only one requester active: that requester wins;
- both active: the requester named by the pointer wins.
REQ-023 ISSUE lasts exactly one cycle. In it the block shall assert dram_write_en=1 and reqN_ack=1 for the winner only, then go to WAIT_BUSY.
REQ-024 Latency: a request sampled at rising edge k in IDLE shall produce dram_write_en and ack high during cycle k+1.
REQ-025 WAIT_BUSY: a cycle counter starts at 0.
- dram_write_busy=1: go to WAIT_DONE.
- counter reaches BUSY_TIMEOUT first: set timeout_err=1, update the pointer, go to IDLE; no grant_cnt increment.
REQ-026 WAIT_DONE: on dram_write_busy=0, the block shall:
- increment grant_cnt[grant_id];
- set the pointer to the opposite of grant_id;
- go to IDLE.
REQ-027 grant_cnt counters shall wrap from 16'hFFFF to 0 without a flag.
REQ-028 The dram_write_addr, dram_write_len and dram_write_data registers shall change only on the IDLE-to-ISSUE transition and shall hold their value otherwise.
REQ-029 Request inputs shall be ignored outside IDLE.
- A requester that drops reqN_en before ack forfeits the request; no ack is generated for it.
- There is never more than one issue outstanding.
REQ-030 timeout_err shall clear only on reset.

Reset
REQ-031 While reset=1 (asynchronously), the block shall force:
- state=IDLE, pointer=0, grant_id=0;
- dram_write_en=0, req0_ack=0, req1_ack=0, timeout_err=0;
- grant_cnt0=0, grant_cnt1=0;
- dram_write_addr, dram_write_len and dram_write_data all 0.
REQ-032 Reset asserted mid-transaction shall abandon the transaction with no ack and no counter update. The first grant after deassertion shall follow REQ-020.

Verification
REQ-033 Single request: req0_en=1, addr=0x80000000, len=0, busy low, with a model that raises busy 1 cycle after en for 3 cycles.
- Expect dram_write_en and req0_ack exactly 1 cycle after sampling.
- Expect dram_write_addr=0x80000000 and grant_cnt0=1.
REQ-034 Contention: both requests held continuously for 4 transactions.
- Expect grant order 0,1,0,1.
- Expect grant_cnt0=2 and grant_cnt1=2.
REQ-035 Busy blocking: dram_write_busy held 1 while req1_en=1 for 10 cycles.
- Expect no en and no ack during those cycles.
- Expect the grant on the first cycle busy is sampled 0.
REQ-036 Timeout: busy never rises after an issue, BUSY_TIMEOUT=255.
- Expect timeout_err=1 after 255 cycles in WAIT_BUSY.
- Expect the FSM back in IDLE, grant_cnt unchanged, next grant to the other requester.
REQ-037 Reset mid-op: assert reset during WAIT_DONE.
- Expect all outputs 0 immediately, without waiting for a clock edge.
- After release, a pending req1 alone is granted normally.
REQ-038 Field stability: change req0_data while in WAIT_DONE. Expect dram_write_data unchanged until the next grant.
